// File: rtl/sram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_pkg
//
// Shared definitions for the SRAM request arbiter:
//   - master ID encodings stored in the in-order ID FIFO
//   - arbiter FSM state encodings
//   - SRAM transfer size encodings
//   - helper mapping a master ID to its lock state
// ---------------------------------------------------------------------------
package sram_req_arbiter_pkg;

    // Source tag pushed into the ID FIFO for every accepted request
    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    // IDLE: no grant held. LOCK_x: master x owns the port until addr_ok.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_e;

    // Size field carried on the SRAM-like interface
    typedef enum logic [1:0] {
        SRAM_SIZE_BYTE = 2'd0,
        SRAM_SIZE_HALF = 2'd1,
        SRAM_SIZE_WORD = 2'd2
    } sram_size_e;

    // Lock state to enter when the given master stalls on addr_ok
    function automatic arb_state_e arb_lock_state(input logic id);
        return (id == ARB_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// ---------------------------------------------------------------------------
// arb_id_fifo
//
// 1-bit wide synchronous FIFO holding the source ID of every accepted
// request, in acceptance order. Push and pop in the same cycle are allowed
// at any occupancy, including full.
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset (empties the FIFO)
//   push_i   write din_i at the tail
//   pop_i    discard the head entry
//   din_i    ID to store
//   full_o   occupancy == DEPTH
//   empty_o  occupancy == 0
//   head_o   ID at the head (valid when !empty_o)
// ---------------------------------------------------------------------------
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one SRAM-like port between the instruction-fetch master (inst_*)
// and the load/store master (data_*). The granted request is forwarded
// combinationally; each accepted request's source is queued in an in-order
// ID FIFO, which routes every returning data_ok/rdata to its owner.
//
// Ports:
//   clk, resetn                clock / asynchronous active-low reset
//   inst_* / data_* inputs     req, wr, size, wstrb, addr, wdata per master
//   inst_/data_addr_ok         request accepted (granted master only)
//   inst_/data_data_ok, rdata  response routed from the memory side
//   mem_* outputs              forwarded request towards the bridge
//   mem_addr_ok/data_ok/rdata  memory-side handshake and response
//   err_spurious               sticky: data_ok seen with nothing outstanding
//
// Build option:
//   SRAM_ARB_RR_EN  round-robin arbitration in IDLE (default: data priority)
// ---------------------------------------------------------------------------
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_spurious
);

    arb_state_e state_q, state_d;
    logic       grant_vld;
    logic       grant_id;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       err_spurious_q, err_spurious_d;
`ifdef SRAM_ARB_RR_EN
    logic       last_grant_q, last_grant_d;
`endif

    // Grant selection and next state. A lock pins the grant to its owner so
    // the forwarded payload cannot change under a pending handshake. The
    // full check uses the pre-pop occupancy, so a pop never enables a grant
    // in the same cycle. Grants are suppressed while in reset so mem_req and
    // the addr_ok outputs stay low even if the masters are requesting.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = ARB_ID_INST;
        case (state_q)
            ARB_IDLE: begin
                if (!fifo_full) begin
`ifdef SRAM_ARB_RR_EN
                    if (inst_req && data_req) begin
                        grant_vld = 1'b1;
                        grant_id  = ~last_grant_q;
                    end else if (data_req) begin
`else
                    if (data_req) begin
`endif
                        grant_vld = 1'b1;
                        grant_id  = ARB_ID_DATA;
                    end else if (inst_req) begin
                        grant_vld = 1'b1;
                        grant_id  = ARB_ID_INST;
                    end
                end
            end
            ARB_LOCK_I: begin
                grant_vld = 1'b1;
                grant_id  = ARB_ID_INST;
            end
            ARB_LOCK_D: begin
                grant_vld = 1'b1;
                grant_id  = ARB_ID_DATA;
            end
            default: begin
                grant_vld = 1'b0;
            end
        endcase
        grant_vld = grant_vld & resetn;

        mem_req = grant_vld & ((grant_id == ARB_ID_DATA) ? data_req : inst_req);

        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = arb_lock_state(grant_id);
                end
            end
            ARB_LOCK_I, ARB_LOCK_D: begin
                // Leaves on acceptance, or when the owner withdraws its request
                if (!mem_req || mem_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Payload follows the grant; with no grant the inst side passes through
    assign mem_wr    = (grant_id == ARB_ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (grant_id == ARB_ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (grant_id == ARB_ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (grant_id == ARB_ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (grant_id == ARB_ID_DATA) ? data_wdata : inst_wdata;

    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & (grant_id == ARB_ID_INST);
    assign data_addr_ok = push & (grant_id == ARB_ID_DATA);

    // Responses return in acceptance order, so the FIFO head names the owner
    assign pop          = mem_data_ok & ~fifo_empty;
    assign inst_data_ok = pop & (fifo_head == ARB_ID_INST);
    assign data_data_ok = pop & (fifo_head == ARB_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign err_spurious_d = err_spurious_q | (mem_data_ok & fifo_empty);
    assign err_spurious   = err_spurious_q;

`ifdef SRAM_ARB_RR_EN
    assign last_grant_d = push ? grant_id : last_grant_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ARB_IDLE;
            err_spurious_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant_q   <= ARB_ID_INST;
`endif
        end else begin
            state_q        <= state_d;
            err_spurious_q <= err_spurious_d;
`ifdef SRAM_ARB_RR_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (grant_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
//
// Self-checking bench for sram_req_arbiter. Directed scenarios use constant
// expectations; the random scenario compares every cycle against a
// transaction-level model (a queue of outstanding owners, the current port
// holder and the round-robin history).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_req_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .err_spurious (err_spurious)
    );

    // ---------------- reference model ----------------
    // q: owners of accepted requests awaiting data (0=inst, 1=data)
    // owner: master holding the port after a stalled request, -1 if none
    int q[$];
    int owner  = -1;
    bit last_g = 1'b0;
    bit spur   = 1'b0;

    typedef struct {
        int gid;
        bit mreq;
        bit iaok;
        bit daok;
        bit idok;
        bit ddok;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        e.gid = -1; e.mreq = 0; e.iaok = 0; e.daok = 0; e.idok = 0; e.ddok = 0;
        if (!resetn) return e;
        if (owner >= 0) begin
            e.gid = owner;
        end else if (q.size() < MAXO) begin
            if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
                e.gid = last_g ? 0 : 1;
`else
                e.gid = 1;
`endif
            end else if (data_req) begin
                e.gid = 1;
            end else if (inst_req) begin
                e.gid = 0;
            end
        end
        e.mreq = (e.gid == 1) ? data_req : (e.gid == 0) ? inst_req : 1'b0;
        e.iaok = (e.gid == 0) && e.mreq && mem_addr_ok;
        e.daok = (e.gid == 1) && e.mreq && mem_addr_ok;
        if (mem_data_ok && q.size() > 0) begin
            e.idok = (q[0] == 0);
            e.ddok = (q[0] == 1);
        end
        return e;
    endfunction

    always @(posedge clk or negedge resetn) begin : model_update
        exp_t e;
        if (!resetn) begin
            q.delete();
            owner  = -1;
            last_g = 1'b0;
            spur   = 1'b0;
        end else begin
            e = model_eval();
            if (mem_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else spur = 1'b1;
            end
            if (e.mreq && mem_addr_ok) begin
                q.push_back(e.gid);
                last_g = (e.gid == 1);
            end
            owner = (e.mreq && !mem_addr_ok) ? e.gid : -1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit ir, input bit dr, input bit mao, input bit mdo,
                         input logic [31:0] rd);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = mao;
        mem_data_ok = mdo;
        mem_rdata   = rd;
    endtask

    task automatic set_addrs(input logic [31:0] ia, input logic [31:0] da);
        inst_addr = ia;
        data_addr = da;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [5:0] oks;
        drive(1, 1, 1, 1, 32'h0);
        #1;
        oks = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_spurious};
        checks++;
        if (oks !== 6'b0) begin errors++; $display("[TB] FAIL reset_initial: got %b expected 000000", oks); end
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 0, 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL reset_fetch%0d: inst_addr_ok=%b expected 1", i, inst_addr_ok); end
            @(negedge clk);
        end
        resetn = 1'b0;
        drive(1, 1, 1, 1, 32'hDEAD);
        #1;
        oks = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_spurious};
        checks++;
        if (oks !== 6'b0) begin errors++; $display("[TB] FAIL reset_midop: got %b expected 000000", oks); end
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 1, 32'h55);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset_fifo_empty: data_ok=%b expected 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        #1;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("[TB] FAIL spurious_set: err_spurious=%b expected 1", err_spurious); end
        @(negedge clk);
        #1;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("[TB] FAIL spurious_sticky: err_spurious=%b expected 1", err_spurious); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (err_spurious !== 1'b0) begin errors++; $display("[TB] FAIL spurious_clear: err_spurious=%b expected 0", err_spurious); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_priority();
        set_addrs(32'h1000_0040, 32'h2000_0080);
        drive(1, 1, 1, 0, 32'h0);
        #1;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b101) begin errors++; $display("[TB] FAIL prio_grant: req/iok/dok=%b expected 101", {mem_req, inst_addr_ok, data_addr_ok}); end
        checks++;
        if (mem_addr !== 32'h2000_0080) begin errors++; $display("[TB] FAIL prio_addr: mem_addr=%h expected 20000080", mem_addr); end
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0);
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL prio_second: iok/dok=%b expected 10", {inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hA);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hA) begin errors++; $display("[TB] FAIL prio_resp1: iok/dok=%b rdata=%h expected 01 0000000a", {inst_data_ok, data_data_ok}, data_rdata); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hB);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hB) begin errors++; $display("[TB] FAIL prio_resp2: iok/dok=%b rdata=%h expected 10 0000000b", {inst_data_ok, data_data_ok}, inst_rdata); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        set_addrs(32'h1111_0000, 32'h2222_0000);
        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h1111_0000 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
                errors++; $display("[TB] FAIL lock_hold%0d: req=%b addr=%h iok=%b dok=%b expected 1 11110000 0 0", i, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
            end
            @(negedge clk);
            drive(1, 1, 0, 0, 32'h0);
        end
        drive(1, 1, 1, 0, 32'h0);
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1111_0000) begin errors++; $display("[TB] FAIL lock_accept: iok/dok=%b addr=%h expected 10 11110000", {inst_addr_ok, data_addr_ok}, mem_addr); end
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h0);
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || mem_addr !== 32'h2222_0000) begin errors++; $display("[TB] FAIL lock_then_data: dok=%b addr=%h expected 1 22220000", data_addr_ok, mem_addr); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h11);
        #1;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h11) begin errors++; $display("[TB] FAIL lock_resp_i: ok=%b rdata=%h expected 1 00000011", inst_data_ok, inst_rdata); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h22);
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h22) begin errors++; $display("[TB] FAIL lock_resp_d: ok=%b rdata=%h expected 1 00000022", data_data_ok, data_rdata); end
        @(negedge clk);
        // Owner withdraws while locked: the other master waits one cycle
        drive(0, 1, 0, 0, 32'h0);
        #1;
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0);
        #1;
        checks++;
        if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL lock_drop: req=%b iok=%b expected 0 0", mem_req, inst_addr_ok); end
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0);
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL lock_drop_idle: iok=%b expected 1", inst_addr_ok); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h33);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL lock_drop_nopush: iok/dok=%b expected 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
    endtask

    task automatic test_full();
        drive(1, 0, 1, 0, 32'h0);
        for (int i = 0; i < MAXO; i++) begin
            #1;
            checks++;
            if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL full_fill%0d: iok=%b expected 1", i, inst_addr_ok); end
            @(negedge clk);
        end
        drive(1, 1, 1, 0, 32'h0);
        #1;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000) begin errors++; $display("[TB] FAIL full_block: req/iok/dok=%b expected 000", {mem_req, inst_addr_ok, data_addr_ok}); end
        @(negedge clk);
        drive(1, 0, 1, 1, 32'h100);
        #1;
        checks++;
        if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b001) begin errors++; $display("[TB] FAIL full_pop_block: req/iok/idok=%b expected 001", {mem_req, inst_addr_ok, inst_data_ok}); end
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0);
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL full_regrant: iok=%b expected 1", inst_addr_ok); end
        @(negedge clk);
        for (int i = 0; i < MAXO; i++) begin
            drive(0, 0, 0, 1, 32'h200 + i);
            #1;
            checks++;
            if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h200 + i) begin errors++; $display("[TB] FAIL full_drain%0d: ok=%b rdata=%h expected 1 %h", i, inst_data_ok, inst_rdata, 32'h200 + i); end
            @(negedge clk);
        end
    endtask

    task automatic test_push_pop();
        int ids[10];
        drive(0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL pp_fill%0d: dok=%b expected 1", i, data_addr_ok); end
            @(negedge clk);
        end
        drive(1, 0, 1, 1, 32'hAA);
        #1;
        checks++;
        if ({inst_addr_ok, data_data_ok} !== 2'b11 || data_rdata !== 32'hAA) begin errors++; $display("[TB] FAIL pp_same: iaok/ddok=%b rdata=%h expected 11 000000aa", {inst_addr_ok, data_data_ok}, data_rdata); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hBB);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("[TB] FAIL pp_order1: iok/dok=%b expected 01", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hCC);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL pp_order2: iok/dok=%b expected 10", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        // Ten single-master transactions, each pop overlapping the next push
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) ids[i] = int'($urandom_range(0, 1));
            drive(i < 10 && ids[i] == 0, i < 10 && ids[i] == 1, i < 10, i > 0, 32'h500 + i);
            #1;
            if (i < 10) begin
                checks++;
                if ({inst_addr_ok, data_addr_ok} !== (ids[i] == 1 ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL wrap_accept%0d: iok/dok=%b id=%0d", i, {inst_addr_ok, data_addr_ok}, ids[i]); end
            end
            if (i > 0) begin
                checks++;
                if ({inst_data_ok, data_data_ok} !== (ids[i-1] == 1 ? 2'b01 : 2'b10) ||
                    (ids[i-1] == 1 ? data_rdata : inst_rdata) !== 32'h500 + i) begin
                    errors++; $display("[TB] FAIL wrap_resp%0d: iok/dok=%b expected id %0d", i - 1, {inst_data_ok, data_data_ok}, ids[i-1]);
                end
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 32'hDD);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL pp_extra: iok/dok=%b expected 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        #1;
        checks++;
        if (err_spurious !== 1'b1) begin errors++; $display("[TB] FAIL pp_spurious: err_spurious=%b expected 1", err_spurious); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_rr();
        bit exp_data;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            drive(1, 1, 1, i > 0, 32'h700 + i);
            #1;
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {~exp_data, exp_data}) begin errors++; $display("[TB] FAIL arb_seq%0d: iok/dok=%b expected %b", i, {inst_addr_ok, data_addr_ok}, {~exp_data, exp_data}); end
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 32'h7FF);
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== {~exp_data, exp_data}) begin errors++; $display("[TB] FAIL arb_last_resp: iok/dok=%b expected %b", {inst_data_ok, data_data_ok}, {~exp_data, exp_data}); end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t e;
        logic [70:0] got_pl, exp_pl;
        for (int c = 0; c < 400; c++) begin
            inst_wr    = 1'($urandom);
            inst_size  = 2'($urandom_range(0, 2));
            inst_wstrb = 4'($urandom);
            inst_addr  = $urandom;
            inst_wdata = $urandom;
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom);
            #1;
            e = model_eval();
            checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_spurious} !==
                {e.mreq, e.iaok, e.daok, e.idok, e.ddok, spur}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d: got %b expected %b", c,
                    {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_spurious},
                    {e.mreq, e.iaok, e.daok, e.idok, e.ddok, spur});
            end
            if (e.mreq) begin
                got_pl = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
                exp_pl = (e.gid == 1) ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                                      : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
                checks++;
                if (got_pl !== exp_pl) begin errors++; $display("[TB] FAIL rand_payload cyc %0d: got %h expected %h", c, got_pl, exp_pl); end
            end
            if (e.idok || e.ddok) begin
                checks++;
                if ((e.idok ? inst_rdata : data_rdata) !== mem_rdata) begin errors++; $display("[TB] FAIL rand_rdata cyc %0d: got %h expected %h", c, e.idok ? inst_rdata : data_rdata, mem_rdata); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_wdata = 32'h0;
        data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF; data_wdata = 32'hCAFE_0000;
        set_addrs(32'h1000_0000, 32'h2000_0000);
        drive(0, 0, 0, 0, 32'h0);
        test_reset();
        test_priority();
        test_lock();
        test_full();
        test_push_pop();
        test_rr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master (inst_*) and the EXE-stage load/store master (data_*).
- Forwards the granted request combinationally: req/wr/size/wstrb/addr/wdata going down, addr_ok coming back.
- Records the source of every accepted request in an in-order ID FIFO, and uses it to route each returning data_ok/rdata to the correct master.
- Sits between the pipeline stages and the SRAM-to-AXI bridge.

Parameters:
MAX_OUTSTANDING, 4, depth of the ID FIFO = maximum number of accepted requests awaiting data_ok (power of two, ≥2)
CNT_W, $clog2(MAX_OUTSTANDING)+1, width of the occupancy counter

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
inst_req  input  1  fetch request
inst_wr  input  1  write flag (0 for fetch)
inst_size  input  2  0=byte, 1=half, 2=word
inst_wstrb  input  4  byte strobes
inst_addr  input  32  address
inst_wdata  input  32  write data
inst_addr_ok  output  1  fetch request accepted
inst_data_ok  output  1  fetch response valid
inst_rdata  output  32  fetch response data
data_req  input  1  load/store request
data_wr  input  1  1=store
data_size  input  2  size
data_wstrb  input  4  strobes
data_addr  input  32  address
data_wdata  input  32  store data
data_addr_ok  output  1  load/store accepted
data_data_ok  output  1  load/store response valid
data_rdata  output  32  load data
mem_req  output  1  request to memory side
mem_wr  output  1  forwarded write flag
mem_size  output  2  forwarded size
mem_wstrb  output  4  forwarded strobes
mem_addr  output  32  forwarded address
mem_wdata  output  32  forwarded write data
mem_addr_ok  input  1  memory accepted request
mem_data_ok  input  1  memory response (in acceptance order)
mem_rdata  input  32  response data
err_spurious  output  1  sticky: mem_data_ok arrived while no request was outstanding

Behaviour:
- Reset: asynchronous, active-low. While resetn=0:
  - FSM=IDLE; FIFO empty; count=0; err_spurious=0.
  - mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok all 0.
  - mem_* payload and *_rdata pass through data (value irrelevant).
- FSM states:
  - IDLE: no grant held.
  - LOCK_I: instruction master owns the port, request not yet accepted.
  - LOCK_D: data master owns the port, request not yet accepted.
- Grant selection in IDLE (combinational, same cycle):
  - If the FIFO is full (count==MAX_OUTSTANDING), no grant and mem_req=0.
  - Otherwise data_req has priority over inst_req.
- While a grant is active:
  - mem_req equals the granted master's req.
  - mem_* payload is muxed from the granted master.
  - The granted master's addr_ok = mem_addr_ok & mem_req. The other master's addr_ok = 0.
- Transitions:
  - IDLE→LOCK_x when x is granted, mem_req=1 and mem_addr_ok=0.
  - LOCK_x→IDLE on mem_addr_ok=1.
  - LOCK_x also returns to IDLE if x_req drops before acceptance (no push).
  - In LOCK_x the other master is never granted, even if it has higher priority. This keeps the payload stable until the handshake completes.
- Zero-latency acceptance: an IDLE grant with mem_addr_ok=1 in the same cycle pushes the ID and stays in IDLE.
- Push: on every mem_req & mem_addr_ok, ID (0=inst, 1=data) is written at the tail.
- Pop:
  - On mem_data_ok with FIFO non-empty, the head is popped.
  - head=0 → inst_data_ok=1, inst_rdata=mem_rdata.
  - head=1 → data_data_ok=1, data_rdata=mem_rdata.
  - data_ok outputs are combinational.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance. This is also legal when the FIFO is full, because the full check uses pre-pop count, so no grant is possible when full anyway.
- mem_data_ok with FIFO empty: no master sees data_ok; err_spurious is set and holds until reset.
- Pointers: log2(MAX_OUTSTANDING) bits, wrap naturally. count is saturating-free; its range is guaranteed by the full gating.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin. A 1-bit last_grant register (reset 0 = inst) updates on each push.
  - When both masters request, the one not equal to last_grant wins.
- Undefined: fixed data priority as above. No last_grant register exists.

Decomposition:
- Shared package (mycpu.h-style defines) holds:
  - ID encodings ARB_ID_INST=1'b0, ARB_ID_DATA=1'b1.
  - FSM state encodings ARB_IDLE/ARB_LOCK_I/ARB_LOCK_D.
  - SRAM size encodings.
- One natural sub-module: arb_id_fifo, a parameterised 1-bit-wide synchronous FIFO with push, pop, full, empty and head outputs, using the same clk/resetn.

Test Plan:
1. Reset mid-operation: issue 2 accepted fetches, assert resetn=0 → count=0 and all ok outputs 0. A subsequent mem_data_ok sets err_spurious=1.
2. Simultaneous inst_req and data_req, mem_addr_ok=1 → data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr. Next cycle inst_addr_ok=1. Two mem_data_ok responses (rdata 0xA, 0xB) → data_rdata=0xA, then inst_rdata=0xB.
3. Lock: inst granted with mem_addr_ok held 0 for 3 cycles while data_req rises → mem_addr stays inst_addr. On acceptance the FSM returns to IDLE and data is granted next.
4. Full: 4 fetches accepted with no data_ok → 5th req gives mem_req=0. A mem_data_ok and a new request in the same cycle → still blocked that cycle, granted the next.
5. Pop+push in the same cycle at count=2 → count stays 2. Pointer wrap over 10 transactions → responses are returned in order.
6. SRAM_ARB_RR_EN defined, both masters requesting continuously → grants alternate data, inst, data, inst.
